// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared constants and types for the execute stage.
//   - ALU opcode encodings carried on esi_alu_opcode
//   - REG_INVALID: destination address meaning "no register write"
//   - mul/div FSM state encoding and operation kind
//   - is_muldiv(): true for the opcodes handled by the iterative unit
package exe_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int MD_ITER  = 16;                // one iteration per data bit
  localparam int MD_CNT_W = $clog2(MD_ITER);

  // R0 is the hardwired zero register, so addressing it never writes.
  localparam logic [3:0] REG_INVALID = 4'h0;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_NOT  = 8'h06;
  localparam logic [7:0] OP_SLL  = 8'h07;
  localparam logic [7:0] OP_SRL  = 8'h08;
  localparam logic [7:0] OP_SRA  = 8'h09;
  localparam logic [7:0] OP_SLT  = 8'h0A;
  localparam logic [7:0] OP_SLTU = 8'h0B;
  localparam logic [7:0] OP_CMP  = 8'h0C;
  localparam logic [7:0] OP_MOV1 = 8'h0D;
  localparam logic [7:0] OP_MOV2 = 8'h0E;
  localparam logic [7:0] OP_MUL  = 8'h10;
  localparam logic [7:0] OP_DIV  = 8'h11;
  localparam logic [7:0] OP_REM  = 8'h12;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_op_e;

  function automatic logic is_muldiv(input logic [7:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
//   master: upstream/downstream environment (drives esi_*, observes eso_*)
//   slave : the execute stage (observes esi_*, drives eso_*)
//
// Flow control: there is no valid/ready pair. esi_hold=1 from MEM freezes
// this stage completely for that cycle. eso_stall=1 tells ID/EX and earlier
// stages to keep presenting the same instruction; the stage consumes the
// instruction on the first rising edge where eso_stall was 0 in the cycle
// before it.
interface exe_stage_if;
  logic        esi_hold;
  logic [15:0] esi_instr;
  logic [15:0] esi_pc;
  logic [7:0]  esi_alu_opcode;
  logic [15:0] esi_op1;
  logic [15:0] esi_op2;
  logic [3:0]  esi_wreg_addr;
  logic [1:0]  esi_rwe;

  logic [15:0] eso_instr;
  logic [15:0] eso_pc;
  logic [15:0] eso_result;
  logic [15:0] eso_op2;
  logic [3:0]  eso_wreg_addr;
  logic [1:0]  eso_rwe;
  logic        eso_stall;

  modport master (
    output esi_hold, esi_instr, esi_pc, esi_alu_opcode, esi_op1, esi_op2,
           esi_wreg_addr, esi_rwe,
    input  eso_instr, eso_pc, eso_result, eso_op2, eso_wreg_addr, eso_rwe,
           eso_stall
  );

  modport slave (
    input  esi_hold, esi_instr, esi_pc, esi_alu_opcode, esi_op1, esi_op2,
           esi_wreg_addr, esi_rwe,
    output eso_instr, eso_pc, eso_result, eso_op2, eso_wreg_addr, eso_rwe,
           eso_stall
  );
endinterface

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative unsigned multiply / divide / remainder unit.
//   clk, rst   : clock, synchronous active-high reset (aborts any operation)
//   hold       : freezes state, counter and datapath
//   start      : sampled only in IDLE; opcode/op_a/op_b captured then
//   busy, done : BUSY for MD_ITER edges, then DONE for one cycle
//   result     : valid while done=1
//   state      : current FSM state, exported for observation
// Shift-add multiply keeps the low 16 product bits. Restoring division with a
// zero divisor naturally yields quotient 0xFFFF and remainder = dividend.
module exe_muldiv
  import exe_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              start,
  input  logic [7:0]        opcode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output md_state_e         state
);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q;
  md_op_e              kind_q;
  // acc_q: product accumulator (MUL) or partial remainder (DIV/REM)
  // shr_q: multiplier shifting right (MUL) or dividend->quotient shifting left
  // opd_q: multiplicand shifting left (MUL) or divisor (DIV/REM)
  logic [DATA_W-1:0]   acc_q, shr_q, opd_q;
  logic [DATA_W:0]     trial;
  logic                trial_ge;

  assign trial    = {acc_q, shr_q[DATA_W-1]};
  assign trial_ge = trial >= {1'b0, opd_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (start) state_d = MD_BUSY;
      MD_BUSY: if (cnt_q == MD_CNT_W'(MD_ITER - 1)) state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;   // never restarts on the still-present op
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      kind_q  <= MD_MUL;
      acc_q   <= '0;
      shr_q   <= '0;
      opd_q   <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            shr_q  <= op_a;
            opd_q  <= op_b;
            kind_q <= (opcode == OP_MUL) ? MD_MUL :
                      (opcode == OP_DIV) ? MD_DIV : MD_REM;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q + MD_CNT_W'(1);
          if (kind_q == MD_MUL) begin
            if (shr_q[0]) acc_q <= acc_q + opd_q;
            opd_q <= opd_q << 1;
            shr_q <= shr_q >> 1;
          end else begin
            // The restored remainder is always below the divisor, so the
            // 16-bit subtraction cannot lose information.
            acc_q <= trial_ge ? (trial[DATA_W-1:0] - opd_q) : trial[DATA_W-1:0];
            shr_q <= {shr_q[DATA_W-2:0], trial_ge};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q == MD_BUSY);
  assign done   = (state_q == MD_DONE);
  assign result = (kind_q == MD_DIV) ? shr_q : acc_q;
  assign state  = state_q;

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 16-bit pipeline with EX/MEM output latch.
//   esi_clk, esi_rst : clock, synchronous active-high reset
//   bus (slave)      : esi_* from ID/EX plus esi_hold from MEM;
//                      eso_* latched outputs plus eso_stall to ID/EX
// Single-cycle ALU results are registered one edge after presentation.
// Optional macro EXE_MULDIV_EN adds the iterative MUL/DIV/REM unit: the
// stage stalls upstream for 17 cycles, latches bubbles meanwhile, and writes
// the result on the edge leaving DONE. Without it, MUL/DIV/REM produce 0 with
// rwe forced to 0 and eso_stall follows esi_hold.
module exe_stage
  import exe_stage_pkg::*;
(
  input logic         esi_clk,
  input logic         esi_rst,
  exe_stage_if.slave  bus
);

  logic [DATA_W-1:0] a, b, alu_res, next_result;
  logic [1:0]        rwe_in;
  logic              load_bubble, md_stall;

  logic [DATA_W-1:0] instr_q, pc_q, result_q, op2_q;
  logic [3:0]        wreg_q;
  logic [1:0]        rwe_q;

  assign a = bus.esi_op1;
  assign b = bus.esi_op2;

  always_comb begin
    alu_res = '0;
    case (bus.esi_alu_opcode)
      OP_NOP:  alu_res = '0;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_SLL:  alu_res = a << b[3:0];
      OP_SRL:  alu_res = a >> b[3:0];
      OP_SRA:  alu_res = $signed(a) >>> b[3:0];
      OP_SLT:  alu_res = {15'b0, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {15'b0, (a < b)};
      OP_CMP:  alu_res = {15'b0, (a != b)};
      OP_MOV1: alu_res = a;
      OP_MOV2: alu_res = b;
      default: alu_res = '0;
    endcase
  end

`ifdef EXE_MULDIV_EN
  logic              md_start, md_busy, md_done;
  logic [DATA_W-1:0] md_result;
  md_state_e         md_state;

  assign md_start = (md_state == MD_IDLE) && is_muldiv(bus.esi_alu_opcode);

  exe_muldiv u_muldiv (
    .clk    (esi_clk),
    .rst    (esi_rst),
    .hold   (bus.esi_hold),
    .start  (md_start),
    .opcode (bus.esi_alu_opcode),
    .op_a   (a),
    .op_b   (b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .state  (md_state)
  );

  // Stall is raised combinationally in the accept cycle so ID/EX keeps the
  // mul/div instruction on our inputs until DONE.
  assign md_stall    = md_start || md_busy;
  assign load_bubble = md_start || md_busy;
  assign next_result = md_done ? md_result : alu_res;
  assign rwe_in      = bus.esi_rwe;
`else
  assign md_stall    = 1'b0;
  assign load_bubble = 1'b0;
  assign next_result = alu_res;
  assign rwe_in      = is_muldiv(bus.esi_alu_opcode) ? 2'b00 : bus.esi_rwe;
`endif

  assign bus.eso_stall = !esi_rst && (bus.esi_hold || md_stall);

  always_ff @(posedge esi_clk) begin
    if (esi_rst) begin
      instr_q  <= '0;
      pc_q     <= '0;
      result_q <= '0;
      op2_q    <= '0;
      wreg_q   <= REG_INVALID;
      rwe_q    <= '0;
    end else if (!bus.esi_hold) begin
      pc_q  <= bus.esi_pc;
      op2_q <= bus.esi_op2;
      if (load_bubble) begin
        instr_q  <= '0;
        result_q <= '0;
        wreg_q   <= REG_INVALID;
        rwe_q    <= '0;
      end else begin
        instr_q  <= bus.esi_instr;
        result_q <= next_result;
        wreg_q   <= bus.esi_wreg_addr;
        rwe_q    <= rwe_in;
      end
    end
  end

  assign bus.eso_instr     = instr_q;
  assign bus.eso_pc        = pc_q;
  assign bus.eso_result    = result_q;
  assign bus.eso_op2       = op2_q;
  assign bus.eso_wreg_addr = wreg_q;
  assign bus.eso_rwe       = rwe_q;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
  import exe_stage_pkg::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] result;
    logic [15:0] op2;
    logic [3:0]  wreg;
    logic [1:0]  rwe;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic upd_s = 1'b0;
  logic rst_s = 1'b0;
  logic seen_rst = 1'b0;
  logic [69:0] prev_out = '0;
  logic [EXP_W-1:0] exp_q[$];

  exe_stage_if bus();

  exe_stage dut (
    .esi_clk (clk),
    .esi_rst (rst),
    .bus     (bus)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
    upd_s <= !rst && !bus.esi_hold;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "simulation timeout");
  end

  // ---------------- common check ----------------
  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] instr, input logic [15:0] pc,
                       input logic [3:0] wreg, input logic [1:0] rwe);
    bus.esi_alu_opcode = op;
    bus.esi_op1        = a;
    bus.esi_op2        = b;
    bus.esi_instr      = instr;
    bus.esi_pc         = pc;
    bus.esi_wreg_addr  = wreg;
    bus.esi_rwe        = rwe;
  endtask

  task automatic drive_idle();
    drive(OP_NOP, 16'h0, 16'h0, 16'h0, 16'h0, REG_INVALID, 2'b00);
  endtask

  task automatic push_exp(input int c, input logic [15:0] instr, input logic [15:0] pc,
                          input logic [15:0] res, input logic [15:0] op2,
                          input logic [3:0] wreg, input logic [1:0] rwe);
    exp_t e;
    e.cyc = 32'(c); e.instr = instr; e.pc = pc; e.result = res;
    e.op2 = op2; e.wreg = wreg; e.rwe = rwe;
    exp_q.push_back(e);
  endtask

  // Called at 1 time unit after an edge; returns at the same phase.
  task automatic run_alu(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] instr, input logic [15:0] pc,
                         input logic [3:0] wreg, input logic [1:0] rwe,
                         input logic [15:0] exp_res, input int hold_len);
    drive(op, a, b, instr, pc, wreg, rwe);
    push_exp(cyc + 1 + hold_len, instr, pc, exp_res, b, wreg, rwe);
    for (int i = 0; i < hold_len; i++) begin
      bus.esi_hold = 1'b1;
      #1;
      check_val("hold_stall", bus.eso_stall, 1);
      @(posedge clk); #1;
    end
    bus.esi_hold = 1'b0;
    #1;
    check_val("alu_stall", bus.eso_stall, 0);
    @(posedge clk); #1;
  endtask

  // Mul/div op; inputs stay put while eso_stall is high. Optional hold pulse
  // starts 5 cycles into the operation.
  task automatic run_md(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] instr, input logic [15:0] pc,
                        input logic [3:0] wreg, input logic [1:0] rwe,
                        input logic [15:0] exp_res, input int hold_len);
    int n_stall;
    int exp_stall;
    drive(op, a, b, instr, pc, wreg, rwe);
`ifdef EXE_MULDIV_EN
    exp_stall = 17 + hold_len;
    push_exp(cyc + 18 + hold_len, instr, pc, exp_res, b, wreg, rwe);
`else
    exp_stall = 0;
    push_exp(cyc + 1, instr, pc, 16'h0, b, wreg, 2'b00);
`endif
    n_stall = 0;
    for (int i = 0; i < 64; i++) begin
      bus.esi_hold = (hold_len > 0) && (i >= 5) && (i < 5 + hold_len);
      #1;
      if (!bus.eso_stall) break;
      n_stall++;
      @(posedge clk); #1;
    end
    bus.esi_hold = 1'b0;
    check_val("md_stall_cycles", 128'(n_stall), 128'(exp_stall));
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [69:0] cur;
    exp_t e;
    cur = {bus.eso_instr, bus.eso_pc, bus.eso_result, bus.eso_op2,
           bus.eso_wreg_addr, bus.eso_rwe};
    if (rst_s) begin
      seen_rst = 1'b1;
      check_val("reset_outputs", cur, {64'h0, REG_INVALID, 2'b00});
    end else if (seen_rst && upd_s) begin
      if (bus.eso_instr != 16'h0) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", {32'(cyc), cur}, 128'h0);
        end else begin
          e = exp_q.pop_front();
          check_val("write", {32'(cyc), cur}, e);
        end
      end else begin
        check_val("bubble", {bus.eso_result, bus.eso_wreg_addr, bus.eso_rwe},
                  {16'h0, REG_INVALID, 2'b00});
      end
    end else if (seen_rst) begin
      check_val("hold_frozen", cur, prev_out);
    end
    prev_out = cur;
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.esi_hold = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_alu(OP_ADD,  16'h7FFF, 16'h0001, 16'h1001, 16'h0002, 4'd1,  2'b01, 16'h8000, 0);
    run_alu(OP_SRA,  16'h8000, 16'h0003, 16'h1002, 16'h0004, 4'd2,  2'b10, 16'hF000, 0);
    run_alu(OP_SLT,  16'hFFFF, 16'h0001, 16'h1003, 16'h0006, 4'd3,  2'b01, 16'h0001, 0);
    run_alu(OP_SLTU, 16'hFFFF, 16'h0001, 16'h1004, 16'h0008, 4'd4,  2'b11, 16'h0000, 0);
    run_alu(OP_SUB,  16'h0000, 16'h0001, 16'h1005, 16'h000A, 4'd5,  2'b01, 16'hFFFF, 0);
    run_alu(OP_AND,  16'hF0F0, 16'h0FF0, 16'h1006, 16'h000C, 4'd6,  2'b01, 16'h00F0, 0);
    run_alu(OP_OR,   16'hF0F0, 16'h0FF0, 16'h1007, 16'h000E, 4'd7,  2'b01, 16'hFFF0, 0);
    run_alu(OP_XOR,  16'hF0F0, 16'h0FF0, 16'h1008, 16'h0010, 4'd8,  2'b01, 16'hFF00, 0);
    run_alu(OP_NOT,  16'h1234, 16'h5555, 16'h1009, 16'h0012, 4'd9,  2'b01, 16'hEDCB, 0);
    run_alu(OP_SLL,  16'h0001, 16'h001F, 16'h100A, 16'h0014, 4'd10, 2'b01, 16'h8000, 0);
    run_alu(OP_SRL,  16'h8000, 16'h0004, 16'h100B, 16'h0016, 4'd11, 2'b01, 16'h0800, 0);
    run_alu(OP_SLL,  16'h00A5, 16'h0010, 16'h100C, 16'h0018, 4'd12, 2'b01, 16'h00A5, 0);
    run_alu(OP_CMP,  16'h1234, 16'h1234, 16'h100D, 16'h001A, 4'd13, 2'b00, 16'h0000, 0);
    run_alu(OP_CMP,  16'h1234, 16'h1235, 16'h100E, 16'h001C, 4'd14, 2'b00, 16'h0001, 0);
    run_alu(OP_MOV1, 16'h1111, 16'h2222, 16'h100F, 16'h001E, 4'd15, 2'b01, 16'h1111, 0);
    run_alu(OP_MOV2, 16'h1111, 16'h2222, 16'h1010, 16'h0020, 4'd1,  2'b10, 16'h2222, 0);
    run_alu(8'hFF,   16'h1234, 16'h5678, 16'h1011, 16'h0022, 4'd2,  2'b11, 16'h0000, 0);
    run_alu(OP_NOP,  16'h1234, 16'h5678, 16'h1012, 16'h0024, 4'd3,  2'b01, 16'h0000, 0);
    run_alu(OP_ADD,  16'h0003, 16'h0004, 16'h1013, 16'h0026, 4'd4,  2'b01, 16'h0007, 2);

    run_md(OP_MUL, 16'h0123, 16'h0045, 16'h2001, 16'h0100, 4'd3, 2'b01, 16'h4E6F, 0);
    run_md(OP_MUL, 16'h0123, 16'h0045, 16'h2002, 16'h0102, 4'd3, 2'b01, 16'h4E6F, 3);
    run_md(OP_DIV, 16'h1234, 16'h0010, 16'h2003, 16'h0104, 4'd5, 2'b01, 16'h0123, 0);
    run_md(OP_REM, 16'h1234, 16'h0010, 16'h2004, 16'h0106, 4'd6, 2'b01, 16'h0004, 0);
    run_md(OP_DIV, 16'h1234, 16'h0000, 16'h2005, 16'h0108, 4'd7, 2'b01, 16'hFFFF, 0);
    run_md(OP_REM, 16'h1234, 16'h0000, 16'h2006, 16'h010A, 4'd8, 2'b01, 16'h1234, 0);
    run_md(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h2007, 16'h010C, 4'd9, 2'b10, 16'h0001, 0);
    run_md(OP_DIV, 16'hFFFF, 16'h00FF, 16'h2008, 16'h010E, 4'd10, 2'b01, 16'h0101, 0);

    // Reset in the middle of a MUL: operation aborted, nothing written.
    drive(OP_MUL, 16'h0123, 16'h0045, 16'hA100, 16'h0200, 4'd5, 2'b01);
`ifdef EXE_MULDIV_EN
    repeat (5) begin
      #1;
      check_val("busy_stall", bus.eso_stall, 1);
      @(posedge clk); #1;
    end
`else
    push_exp(cyc + 1, 16'hA100, 16'h0200, 16'h0000, 16'h0045, 4'd5, 2'b00);
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    #1;
    check_val("rst_stall", bus.eso_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    #1;
    check_val("post_rst_stall", bus.eso_stall, 0);
    @(posedge clk); #1;
    run_alu(OP_ADD, 16'h1000, 16'h0234, 16'h3001, 16'h0300, 4'd6, 2'b01, 16'h1234, 0);

    drive_idle();
    repeat (5) @(posedge clk);
    #1;
    check_val("queue_drain", 128'(exp_q.size()), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
